// File: rtl/uart_pkg.sv
// Shared UART definitions: state codes (common with the transmit FSM),
// frame geometry and parity-sense constants.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } uart_state_t;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receive-side signal bundle: serial line in, byte plus status out.
interface uart_rx_fsm_if;
  import uart_pkg::*;

  // rx_valid is a one-cycle strobe with no ready: rx_data/parity_err/frame_err
  // change only in the strobe cycle and hold until the next one.
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output rx_in,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx_in,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value
// is selectable so idle-high lines come out of reset already idle.
module uart_rx_sync #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Samples at bit centres measured from each synchronized start edge.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_fsm_if.slave bus,
  output uart_state_t  state_dbg
);

  localparam logic [7:0] BAUD_MID  = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  uart_state_t          state, state_nxt;
  logic [7:0]           baud, baud_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic                 armed, armed_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_acc, par_nxt;
  logic                 perr, perr_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 valid_q, valid_nxt;
  logic                 perr_q, perr_q_nxt;
  logic                 ferr_q, ferr_nxt;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_in),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      armed   <= 1'b0;
      shift   <= '0;
      par_acc <= 1'b0;
      perr    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_cnt <= bit_nxt;
      armed   <= armed_nxt;
      shift   <= shift_nxt;
      par_acc <= par_nxt;
      perr    <= perr_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      perr_q  <= perr_q_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud + 8'd1;
    bit_nxt    = bit_cnt;
    armed_nxt  = armed;
    shift_nxt  = shift;
    par_nxt    = par_acc;
    perr_nxt   = perr;
    data_nxt   = data_q;
    valid_nxt  = 1'b0;
    perr_q_nxt = perr_q;
    ferr_nxt   = ferr_q;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        // A start is accepted only after the line has been seen high, so a
        // held-low break cannot retrigger frames.
        if (rx_s) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = START;
          armed_nxt = 1'b0;
        end
      end
      START: begin
        if (baud == BAUD_MID) begin
          baud_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            par_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
            armed_nxt = 1'b1;
          end
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          par_nxt   = par_acc ^ rx_s;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          perr_nxt  = ((par_acc ^ rx_s) != PARITY_ODD);
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_nxt   = '0;
          state_nxt  = IDLE;
          data_nxt   = shift;
          perr_q_nxt = perr;
          ferr_nxt   = ~rx_s;
          valid_nxt  = 1'b1;
          armed_nxt  = rx_s;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
      end
    endcase
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: table of clean/parity-error frames plus
// hand sequences for break, glitch, back-to-back and mid-frame reset.
module tb_uart_rx_fsm;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic        clk;
  logic        rst;
  uart_state_t state_dbg;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          start_cyc = 0;

  logic [9:0] exp_q[$];
  int         strobe_hist[$];

  uart_rx_fsm_if bus_if ();

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus_if.rx_valid === 1'b1) begin
      strobe_hist.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_strobe: got data=%02h want no strobe", bus_if.rx_data);
      end else begin
        chk("strobe_data_perr_ferr",
            {22'd0, bus_if.rx_data, bus_if.parity_err, bus_if.frame_err},
            {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    bus_if.rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], CPB);
      if (i == 3) chk("busy_mid_frame", {31'd0, bus_if.rx_busy}, 32'd1);
    end
    drive_bit(p, CPB);
    drive_bit(s, CPB);
  endtask

  task automatic gap_and_drain(input string name);
    drive_bit(1'b1, CPB);
    chk(name, exp_q.size(), 32'd0);
    chk("idle_busy_low", {31'd0, bus_if.rx_busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int base;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

    rst = 1'b0;
    bus_if.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", {24'd0, bus_if.rx_data}, 32'd0);
    chk("reset_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
    chk("reset_parity_err", {31'd0, bus_if.parity_err}, 32'd0);
    chk("reset_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
    chk("reset_rx_busy", {31'd0, bus_if.rx_busy}, 32'd0);
    chk("reset_state", {29'd0, state_dbg}, {29'd0, IDLE});
    rst = 1'b1;
    repeat (CPB) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      if (i == 0) begin
        // rx_in edge -> rx_s edge is 2 clk; then 10.5 bit times +/- 1.
        lat = (strobe_hist.size() > 0) ? strobe_hist[strobe_hist.size()-1] - start_cyc : -1;
        n_total++;
        if (lat < 2 + CPB * 21 / 2 - 1 || lat > 2 + CPB * 21 / 2 + 1) begin
          n_bad++;
          $display("FAIL latency: got %0d want %0d..%0d", lat, 2 + CPB * 21 / 2 - 1, 2 + CPB * 21 / 2 + 1);
        end
      end
      gap_and_drain("table_strobe_seen");
    end

    // Glitch shorter than half a bit: no strobe, flags from 0x80 frame held.
    drive_bit(1'b0, CPB / 2 - 3);
    drive_bit(1'b1, 3 * CPB);
    chk("glitch_state_idle", {29'd0, state_dbg}, {29'd0, IDLE});
    chk("glitch_data_held", {24'd0, bus_if.rx_data}, 32'h80);
    chk("glitch_perr_held", {31'd0, bus_if.parity_err}, 32'd1);
    chk("glitch_ferr_held", {31'd0, bus_if.frame_err}, 32'd0);

    // Frame error then break: one strobe only, no restart while low.
    exp_q.push_back({8'h55, 1'b0, 1'b1});
    send_frame(8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 3 * CPB);
    chk("break_strobe_seen", exp_q.size(), 32'd0);
    chk("break_busy_low", {31'd0, bus_if.rx_busy}, 32'd0);
    chk("break_state_idle", {29'd0, state_dbg}, {29'd0, IDLE});
    chk("break_ferr_held", {31'd0, bus_if.frame_err}, 32'd1);
    drive_bit(1'b1, CPB);
    exp_q.push_back({8'hF0, 1'b0, 1'b0});
    send_frame(8'hF0, 1'b0, 1'b1);
    gap_and_drain("after_break_strobe_seen");

    // Back-to-back frames, no idle between stop and next start.
    base = strobe_hist.size();
    exp_q.push_back({8'h00, 1'b0, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    gap_and_drain("b2b_strobes_seen");
    chk("b2b_strobe_count", strobe_hist.size() - base, 32'd3);
    for (int k = 1; k < 3; k++) begin
      chk("b2b_spacing",
          (strobe_hist.size() >= base + 3) ? strobe_hist[base+k] - strobe_hist[base+k-1] : 0,
          CPB * 11);
    end

    // Reset in the middle of the data bits of 0xC3.
    base = strobe_hist.size();
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB / 2);
    chk("pre_reset_busy", {31'd0, bus_if.rx_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midreset_rx_data", {24'd0, bus_if.rx_data}, 32'd0);
    chk("midreset_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
    chk("midreset_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
    chk("midreset_rx_busy", {31'd0, bus_if.rx_busy}, 32'd0);
    bus_if.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1, 10 * CPB);
    chk("midreset_no_strobe", strobe_hist.size() - base, 32'd0);
    exp_q.push_back({8'h7E, 1'b0, 1'b0});
    send_frame(8'h7E, 1'b0, 1'b1);
    gap_and_drain("after_reset_strobe_seen");

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Serial receiver that consumes the line produced by the transmit FSM / mux / parity path.
- Frame format is identical to the transmitter: start bit (0), 8 data bits LSB first, 1 parity bit, stop bit (1).
- Oversamples the line, re-centres on every start edge, rebuilds the byte, checks parity and stop bit, and hands the byte to the host with a one-cycle strobe.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal range is 4..255.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Must match the transmitter's parity setting.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx_in  in  1  serial line; asynchronous to clk; idles high.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle strobe: rx_data and the error flags are updated this cycle.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  stop bit sampled as 0 on the last frame.
- rx_busy  out  1  high while a frame is being received.

Behaviour:
- Reset (rst=0, async): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - Synchronizer flops reset to 1; state=IDLE; armed=0; baud and bit counters cleared.
- Input conditioning: 2-flop synchronizer gives rx_s. The FSM uses only rx_s, which lags rx_in by 2 clk.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state change. Bit counter is 3 bits.
- States:
  - IDLE: rx_busy=0.
    - Any cycle with rx_s=1 sets armed=1.
    - If armed and rx_s=0, go to START and clear armed.
  - START: rx_busy=1. When baud count = CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - rx_s=0: go to DATA, baud count cleared, bit count=0.
    - rx_s=1: glitch. Go back to IDLE with armed=1; no strobe, flags unchanged.
  - DATA: sample rx_s when baud count = CLKS_PER_BIT-1.
    - Shift right with the sample entering bit 7, so after 8 samples the byte is LSB-first correct.
    - Fold each sample into the running parity.
    - After the 8th sample (bit count=7), go to PARITY.
  - PARITY: sample at baud count = CLKS_PER_BIT-1 and go to STOP.
    - perr = (xor of data ^ parity sample) != PARITY_ODD.
  - STOP: sample at baud count = CLKS_PER_BIT-1, then on the next edge:
    - rx_data=shift reg, parity_err=perr, frame_err=~sample, rx_valid=1 for exactly one cycle.
    - Go to IDLE. armed is set only if the stop sample was 1.
- Error handling:
  - The byte is delivered even with parity or frame errors.
  - After a frame error (line held low / break), no new start is accepted until rx_s has been 1 for at least one cycle.
- rx_data, parity_err and frame_err hold their values until the next rx_valid. There is no overrun detection; the host must read within one frame time.
- Timing: all samples are at bit centres relative to the rx_s falling edge.
  - Frame length is 10.5*CLKS_PER_BIT cycles from edge to strobe, ±1 cycle.
  - Back-to-back frames (stop bit immediately followed by start) must be received with no loss.
- Reset mid-frame: all state is abandoned immediately, no strobe is issued, and outputs take their reset values. After reset is released, the block waits for armed before accepting a start.
- Outputs are registered. rx_busy is decoded from state (START, DATA, PARITY, STOP = 1).

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE=3'b000, START=3'b001, DATA=3'b010, PARITY=3'b011, STOP=3'b100 (same codes as the transmit FSM);
  - DATA_BITS=8;
  - parity-sense constants.
- One natural sub-module: uart_rx_sync (2-flop synchronizer, reset value 1), reusable for other async inputs.

Test Plan:
- Clean frame: send 0xA5 (even parity, parity bit 0, stop 1) at CLKS_PER_BIT=16 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, rx_busy high for the frame duration.
- Parity error: send 0x3C with parity bit 1 (even mode) -> rx_data=0x3C, parity_err=1, frame_err=0. The next clean frame 0x01 (parity 1) clears parity_err.
- Frame error and break: send 0x55 with stop bit 0, then hold the line low for 3 bit times -> rx_data=0x55, frame_err=1, and no second rx_valid until the line returns high and a new start arrives.
- Glitch rejection: pull rx_in low for CLKS_PER_BIT/2-3 cycles, then high -> no rx_valid, returns to IDLE, flags unchanged.
- Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap -> three rx_valid pulses, each CLKS_PER_BIT*11 cycles apart, carrying the correct bytes.
- Reset mid-frame: assert rst=0 during DATA of 0xC3 -> all outputs go to 0 immediately and no strobe is issued. Release rst and send 0x7E -> received correctly.
